// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the 32-entry register file.
// Merges the single-cycle ALU path with a FIFO-buffered long-latency path
// onto one registered write port, and tracks pending long results in a
// busy scoreboard so decode can stall on them.
module regfile_wb_ctrl #(
    parameter int REGF_WIDTH = 32,
    parameter int LQ_DEPTH   = 2,
    localparam int CW = $clog2(LQ_DEPTH + 1),
    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [REGF_WIDTH-1:0] alu_data,
    input  logic                  lq_valid,
    output logic                  lq_ready,
    input  logic [4:0]            lq_rd,
    input  logic [REGF_WIDTH-1:0] lq_data,
    input  logic                  iss_valid,
    input  logic [4:0]            iss_rd,
    input  logic                  dec_valid,
    input  logic [4:0]            dec_rs1,
    input  logic [4:0]            dec_rs2,
    input  logic [4:0]            dec_rd,
    output logic                  stall,
    output logic                  w_en,
    output logic [4:0]            rd,
    output logic [REGF_WIDTH-1:0] data_w,
    output logic [31:0]           busy,
    output logic [CW-1:0]         lq_count
);

    typedef struct packed {
        logic [4:0]            rd;
        logic [REGF_WIDTH-1:0] data;
    } lq_ent_t;

    lq_ent_t        mem [LQ_DEPTH];
    logic [PW-1:0]  wptr, rptr;
    logic [CW-1:0]  count;
    lq_ent_t        head;
    logic           alu_live, push, pop, pop_live;
    logic [31:0]    busy_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Arbitration and handshake; ready depends only on registered occupancy
    always_comb begin
        head     = mem[rptr];
        lq_ready = (count < CW'(LQ_DEPTH));
        alu_live = alu_valid && (alu_rd != 5'd0);
        push     = lq_valid && lq_ready;
        // x0 heads are popped too, they just produce no write
        pop      = (count != '0) && !alu_live;
        pop_live = pop && (head.rd != 5'd0);
        stall    = dec_valid && (busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]);
        lq_count = count;
    end

    // Scoreboard next state: clear on drain, then set on issue so set wins
    always_comb begin
        busy_nxt = busy;
        if (pop_live)
            busy_nxt[head.rd] = 1'b0;
        if (iss_valid)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // FIFO storage needs no reset; occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{rd: lq_rd, data: lq_data};
    end

    // Pointers, occupancy, scoreboard and the registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            busy   <= '0;
            w_en   <= 1'b0;
            rd     <= 5'd0;
            data_w <= '0;
        end else begin
            busy <= busy_nxt;
            if (push)
                wptr <= ptr_inc(wptr);
            if (pop)
                rptr <= ptr_inc(rptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);

            if (alu_live) begin
                w_en   <= 1'b1;
                rd     <= alu_rd;
                data_w <= alu_data;
            end else if (pop_live) begin
                w_en   <= 1'b1;
                rd     <= head.rd;
                data_w <= head.data;
            end else begin
                w_en   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model of the write side.
module tb_regfile_wb_ctrl;

    localparam int W     = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           alu_valid, lq_valid, iss_valid, dec_valid;
    logic [4:0]     alu_rd, lq_rd, iss_rd, dec_rs1, dec_rs2, dec_rd;
    logic [W-1:0]   alu_data, lq_data;
    logic           lq_ready, stall, w_en;
    logic [4:0]     rd;
    logic [W-1:0]   data_w;
    logic [31:0]    busy;
    logic [CW-1:0]  lq_count;

    regfile_wb_ctrl #(.REGF_WIDTH(W), .LQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lq_valid(lq_valid), .lq_ready(lq_ready), .lq_rd(lq_rd), .lq_data(lq_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .stall(stall), .w_en(w_en), .rd(rd), .data_w(data_w),
        .busy(busy), .lq_count(lq_count)
    );

    always #5 clk = ~clk;

    // Register file stand-in: commits on the negedge inside the write cycle
    logic [W-1:0] rf [32];
    always @(negedge clk) if (w_en && rd != 5'd0) rf[rd] <= data_w;

    // Behavioural model: pending long results in arrival order, a busy set,
    // and the write that should be presented this cycle.
    typedef struct { logic [4:0] rd; logic [W-1:0] d; } ent_t;
    ent_t         q[$];
    logic [31:0]  m_busy;
    logic         m_wen;
    logic [4:0]   m_rd;
    logic [W-1:0] m_data;

    int n_chk = 0;
    int n_pass = 0;

    function automatic logic m_ready();
        return q.size() < DEPTH;
    endfunction

    function automatic logic m_stall();
        return dec_valid && (m_busy[dec_rs1] | m_busy[dec_rs2] | m_busy[dec_rd]);
    endfunction

    task automatic model_reset();
        q.delete();
        m_busy = '0; m_wen = 1'b0; m_rd = '0; m_data = '0;
    endtask

    // What the next clock edge does, from the rules of the block
    task automatic model_edge();
        ent_t e;
        logic rdy;
        rdy = m_ready();
        if (alu_valid && alu_rd != 0) begin
            m_wen = 1'b1; m_rd = alu_rd; m_data = alu_data;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            if (e.rd != 0) begin
                m_wen = 1'b1; m_rd = e.rd; m_data = e.d; m_busy[e.rd] = 1'b0;
            end else m_wen = 1'b0;
        end else m_wen = 1'b0;
        if (lq_valid && rdy) begin
            e.rd = lq_rd; e.d = lq_data; q.push_back(e);
        end
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lq_valid = 0; lq_rd = 0; lq_data = 0;
        iss_valid = 0; iss_rd = 0;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < DEPTH + 1; i++) step();
    endtask

    task automatic test_reset();
        drain();
        iss_valid = 1; iss_rd = 5;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        lq_valid = 1; lq_rd = 20; lq_data = 32'hA0;
        step();
        iss_valid = 0;
        alu_rd = 2; lq_rd = 21; lq_data = 32'hA1;
        step();
        idle();
        alu_valid = 1; alu_rd = 3;
        dec_valid = 1; dec_rs1 = 5;
        #1;
        n_chk++; if (lq_count !== 2'd2) $display("FAIL rst_pre_count got %0d exp 2", lq_count); else n_pass++;
        n_chk++; if (busy[5] !== 1'b1) $display("FAIL rst_pre_busy5 got %0b exp 1", busy[5]); else n_pass++;
        rst_n = 0;
        #1;
        model_reset();
        n_chk++; if (w_en !== 1'b0) $display("FAIL rst_wen got %0b exp 0", w_en); else n_pass++;
        n_chk++; if (busy !== 32'd0) $display("FAIL rst_busy got %h exp 0", busy); else n_pass++;
        n_chk++; if (lq_count !== '0) $display("FAIL rst_count got %0d exp 0", lq_count); else n_pass++;
        n_chk++; if (lq_ready !== 1'b1) $display("FAIL rst_ready got %0b exp 1", lq_ready); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL rst_stall got %0b exp 0", stall); else n_pass++;
        n_chk++; if (rd !== 5'd0 || data_w !== '0) $display("FAIL rst_port got rd=%0d d=%h exp 0/0", rd, data_w); else n_pass++;
        idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_write();
        drain();
        alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
        step();
        n_chk++; if (w_en !== 1'b1 || rd !== 5'd3 || data_w !== 32'hDEADBEEF)
            $display("FAIL alu_write got w=%0b rd=%0d d=%h exp 1/3/deadbeef", w_en, rd, data_w); else n_pass++;
        alu_rd = 0; alu_data = 32'h12345678;
        @(negedge clk); #1;
        n_chk++; if (rf[3] !== 32'hDEADBEEF) $display("FAIL alu_rf_x3 got %h exp deadbeef", rf[3]); else n_pass++;
        step();
        n_chk++; if (w_en !== 1'b0) $display("FAIL alu_x0_wen got %0b exp 0", w_en); else n_pass++;
        n_chk++; if (rd !== 5'd3 || data_w !== 32'hDEADBEEF)
            $display("FAIL alu_hold got rd=%0d d=%h exp 3/deadbeef", rd, data_w); else n_pass++;
        idle();
    endtask

    task automatic test_scoreboard();
        drain();
        iss_valid = 1; iss_rd = 7;
        step();
        idle();
        dec_valid = 1; dec_rs2 = 7;
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL sb_stall_set got %0b exp 1", stall); else n_pass++;
        lq_valid = 1; lq_rd = 7; lq_data = 32'h55;
        step();
        lq_valid = 0;
        n_chk++; if (w_en !== 1'b0 || lq_count !== 2'd1 || stall !== 1'b1)
            $display("FAIL sb_accept got w=%0b cnt=%0d st=%0b exp 0/1/1", w_en, lq_count, stall); else n_pass++;
        step();
        n_chk++; if (w_en !== 1'b1 || rd !== 5'd7 || data_w !== 32'h55)
            $display("FAIL sb_pop got w=%0b rd=%0d d=%h exp 1/7/55", w_en, rd, data_w); else n_pass++;
        n_chk++; if (busy[7] !== 1'b0 || stall !== 1'b0)
            $display("FAIL sb_clear got busy7=%0b st=%0b exp 0/0", busy[7], stall); else n_pass++;
        idle();
    endtask

    task automatic test_priority_full();
        logic [4:0]   lrd[3]  = '{5'd10, 5'd11, 5'd12};
        logic [W-1:0] ldat[3] = '{32'hC0, 32'hC1, 32'hC2};
        logic [4:0]   exp_rd[7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 5'd11, 5'd12};
        int idx = 0;
        logic acc;
        drain();
        for (int c = 0; c < 7; c++) begin
            alu_valid = (c < 4); alu_rd = 5'(c + 1); alu_data = 32'(c + 1);
            lq_valid = (idx < 3);
            lq_rd = (idx < 3) ? lrd[idx] : 5'd0;
            lq_data = (idx < 3) ? ldat[idx] : '0;
            #1;
            if (c == 2) begin
                n_chk++; if (lq_ready !== 1'b0) $display("FAIL pri_full_ready got %0b exp 0", lq_ready); else n_pass++;
            end
            acc = m_ready();
            step();
            if (acc && idx < 3) idx++;
            n_chk++; if (w_en !== 1'b1 || rd !== exp_rd[c])
                $display("FAIL pri_order c=%0d got w=%0b rd=%0d exp 1/%0d", c, w_en, rd, exp_rd[c]); else n_pass++;
        end
        idle();
    endtask

    task automatic test_collision();
        drain();
        iss_valid = 1; iss_rd = 9;
        lq_valid = 1; lq_rd = 9; lq_data = 32'h99;
        step();
        lq_valid = 0;
        step();
        n_chk++; if (w_en !== 1'b1 || rd !== 5'd9 || busy[9] !== 1'b1)
            $display("FAIL coll got w=%0b rd=%0d busy9=%0b exp 1/9/1", w_en, rd, busy[9]); else n_pass++;
        iss_valid = 0;
        drain();
    endtask

    task automatic test_wraparound();
        drain();
        for (int c = 0; c < 8; c++) begin
            lq_valid = (c < 6); lq_rd = 5'(16 + c); lq_data = 32'hF00 + 32'(c);
            alu_valid = (c == 1); alu_rd = 5'd30; alu_data = 32'h3;
            step();
            n_chk++; if (w_en !== m_wen || rd !== m_rd || data_w !== m_data)
                $display("FAIL wrap c=%0d got w=%0b rd=%0d d=%h exp %0b/%0d/%h", c, w_en, rd, data_w, m_wen, m_rd, m_data); else n_pass++;
            n_chk++; if (lq_count > 2'd2 || lq_count !== CW'(q.size()))
                $display("FAIL wrap_count c=%0d got %0d exp %0d", c, lq_count, q.size()); else n_pass++;
        end
        idle();
    endtask

    task automatic test_random();
        drain();
        for (int c = 0; c < 400; c++) begin
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            lq_valid  = ($urandom_range(0, 9) < 6);
            lq_rd     = 5'($urandom_range(0, 7));
            lq_data   = $urandom;
            iss_valid = ($urandom_range(0, 9) < 3);
            iss_rd    = 5'($urandom_range(0, 7));
            dec_valid = $urandom_range(0, 1);
            dec_rs1   = 5'($urandom_range(0, 7));
            dec_rs2   = 5'($urandom_range(0, 7));
            dec_rd    = 5'($urandom_range(0, 7));
            #1;
            n_chk++; if (stall !== m_stall()) $display("FAIL rnd_stall c=%0d got %0b exp %0b", c, stall, m_stall()); else n_pass++;
            n_chk++; if (lq_ready !== m_ready()) $display("FAIL rnd_ready c=%0d got %0b exp %0b", c, lq_ready, m_ready()); else n_pass++;
            step();
            n_chk++; if (w_en !== m_wen || rd !== m_rd || data_w !== m_data)
                $display("FAIL rnd_write c=%0d got %0b/%0d/%h exp %0b/%0d/%h", c, w_en, rd, data_w, m_wen, m_rd, m_data); else n_pass++;
            n_chk++; if (busy !== m_busy) $display("FAIL rnd_busy c=%0d got %h exp %h", c, busy, m_busy); else n_pass++;
            n_chk++; if (lq_count !== CW'(q.size())) $display("FAIL rnd_count c=%0d got %0d exp %0d", c, lq_count, q.size()); else n_pass++;
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        for (int i = 0; i < 32; i++) rf[i] = '0;
        #12 rst_n = 1;
        @(posedge clk); #1;
        test_alu_write();
        test_scoreboard();
        test_priority_full();
        test_collision();
        test_wraparound();
        test_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-side controller for the core's 32-entry register file. It merges results from the single-cycle ALU path and a long-latency result path (loads, multiply/divide), buffering the latter in a small FIFO. It drives the register file's write port (`w_en`, `rd`, `data_w`) with at most one write per cycle. A busy scoreboard lets decode stall on operands whose long-latency results are still pending.

## Interface
- `REGF_WIDTH`, 32, data width; must match the register file.
- `LQ_DEPTH`, 2, long-result FIFO depth (≥1).

- `clk`  in  1  core clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present this cycle; cannot be back-pressured.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  REGF_WIDTH  ALU result.
- `lq_valid`  in  1  long-latency result offered.
- `lq_ready`  out  1  FIFO can accept; `lq_ready = (count < LQ_DEPTH)`.
- `lq_rd`  in  5  long-latency destination.
- `lq_data`  in  REGF_WIDTH  long-latency result.
- `iss_valid`  in  1  long-latency op issued this cycle.
- `iss_rd`  in  5  its destination; marks register busy.
- `dec_valid`  in  1  decode has an instruction to check.
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  decode operand and destination indices.
- `stall`  out  1  combinational hazard flag.
- `w_en`  out  1  register-file write enable; registered.
- `rd`  out  5  register-file write index; registered.
- `data_w`  out  REGF_WIDTH  register-file write data; registered.
- `busy`  out  32  scoreboard bitmap; bit 0 is always 0.
- `lq_count`  out  $clog2(LQ_DEPTH+1)  FIFO occupancy.

## Operation
- **Write sources.**
  - ALU write is "live" when `alu_valid && alu_rd != 0`.
  - FIFO drain is "live" when `count != 0 && head.rd != 0`.
  - A FIFO head with `rd == 0` is popped silently. It produces no write and clears no busy bit.
- **Arbitration.** Fixed priority: ALU first. The FIFO head is popped only in a cycle with no live ALU write.
  - Live ALU write: `w_en<=1`, `rd<=alu_rd`, `data_w<=alu_data`.
  - Else live FIFO pop: `w_en<=1`, `rd/data_w <=` head.
  - Else `w_en<=0`; `rd` and `data_w` hold their values.
- **ALU writes to x0** are dropped: `w_en` stays 0 and the FIFO may drain in that cycle.
- **Enqueue** on `lq_valid && lq_ready`. Enqueue and pop in the same cycle are both allowed; count is unchanged. A full FIFO deasserts `lq_ready`; there is no pass-through when full.
- **FIFO** is circular with read/write pointers wrapping at `LQ_DEPTH`.
- **Scoreboard.**
  - Set `busy[iss_rd]` on `iss_valid && iss_rd != 0`.
  - Clear `busy[head.rd]` on the edge the head is popped with `rd != 0`.
  - Same register set and cleared on the same edge: set wins.
- **Stall.** `stall = dec_valid && (busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd])`. x0 never stalls, and `dec_rd` covers WAW.
- **Reset** (async assert, any time): `w_en=0`, `rd=0`, `data_w=0`, `busy=0`, `count=0`, pointers 0, so `lq_ready=1` and `stall=0`. FIFO contents in flight are discarded.

## Timing
- ALU path: `alu_valid` sampled at edge N → `w_en`/`rd`/`data_w` valid from N until N+1. The register file commits on the negedge inside that cycle.
- Long path: accepted at edge N → earliest pop at edge N+1 → `w_en` high from N+1 until N+2. Each consecutive ALU cycle delays this by one.
- `busy` clears at the same edge `w_en` rises for that entry. `stall` for that register falls in the same cycle the write is presented. The register file's negedge write lands before the next posedge decode read.
- `lq_ready` and `stall` are combinational from registered state (plus `dec_*` for `stall`). There is no input-to-`lq_ready` path.
- Throughput: one write per cycle. Sustained `alu_valid` starves the FIFO indefinitely; this is by design, because the issue logic bounds the outstanding long ops.

## Test plan
- **Reset.** Assert `rst_n=0` mid-run with FIFO holding 2 and `busy[5]=1` → immediately `w_en=0`, `busy=0`, `lq_count=0`, `lq_ready=1`.
- **ALU write and x0 drop.**
  - `alu_valid`, `alu_rd=3`, `alu_data=0xDEADBEEF` at edge N → `w_en=1`, `rd=3`, `data_w=0xDEADBEEF` in cycle N; register file x3 reads 0xDEADBEEF next cycle.
  - `alu_rd=0` → `w_en=0`.
- **Scoreboard.** `iss_rd=7`, then `dec_rs2=7` → `stall=1`. `lq` result (rd 7, 0x55) accepted at N, no ALU → pop at N+1 with `w_en=1`, `rd=7`; `busy[7]=0` and `stall=0` from N+1.
- **Priority and full.** Hold `alu_valid` (rd 1..4) for 4 cycles while offering 3 lq results → `lq_ready=0` after 2 accepts. All 4 ALU writes occur first; FIFO entries are then written in arrival order.
- **Set/clear collision.** Head pop for rd 9 on the same edge as `iss_valid`, `iss_rd=9` → `busy[9]` remains 1.
- **Wrap-around.** 6 enqueue/drain cycles with `LQ_DEPTH=2` → data exits in order with no loss or duplication; `lq_count` never exceeds 2.
